// File: rtl/spi_slave_engine.sv
// spi_slave_engine -- SPI mode-0 responder shift engine, MSB first.
//
// Oversamples the SPI pins in the clk_i domain, shifts MOSI words into an
// RX FIFO and shifts MISO words out of a TX FIFO, several words per frame.
//
// Ports:
//   clk_i, rst_i              system clock (>= 6x sclk), sync active-high reset
//   spi_sclk_i/cs_ni/mosi_i   asynchronous SPI pins
//   spi_miso_o, spi_miso_oe_o slave data out and its enable (frame active)
//   tx_data_i, tx_notempty_i  head of TX FIFO; tx_pop_o one-cycle pop strobe
//   rx_data_o, rx_push_o      received word and one-cycle push strobe
//   rx_notfull_i              RX FIFO can take a word
//   busy_o                    frame in progress
//   rx_overflow_o             sticky: word dropped, RX FIFO full
//   tx_underrun_o             sticky: DUMMY_WORD sent, TX FIFO empty
//   err_clr_i                 clears both sticky flags (set wins)
module spi_slave_engine #(
  parameter int                    DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] DUMMY_WORD = '1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  spi_sclk_i,
  input  logic                  spi_cs_ni,
  input  logic                  spi_mosi_i,
  output logic                  spi_miso_o,
  output logic                  spi_miso_oe_o,
  input  logic [DATA_WIDTH-1:0] tx_data_i,
  input  logic                  tx_notempty_i,
  output logic                  tx_pop_o,
  output logic [DATA_WIDTH-1:0] rx_data_o,
  input  logic                  rx_notfull_i,
  output logic                  rx_push_o,
  output logic                  busy_o,
  output logic                  rx_overflow_o,
  output logic                  tx_underrun_o,
  input  logic                  err_clr_i
);

  localparam int CW = $clog2(DATA_WIDTH + 1);

  localparam logic [1:0] ST_WAIT_IDLE = 2'd0;
  localparam logic [1:0] ST_IDLE      = 2'd1;
  localparam logic [1:0] ST_LOAD      = 2'd2;
  localparam logic [1:0] ST_SHIFT     = 2'd3;

  logic [2:0]            sclk_q, sclk_d;
  logic [1:0]            cs_q, cs_d;
  logic [1:0]            mosi_q, mosi_d;
  // Fills with ones after reset. The cs_n sync flops reset to "idle", which
  // would otherwise let WAIT_IDLE leave before the real pin level arrives
  // and join a frame that is already running.
  logic [1:0]            vld_pipe_q, vld_pipe_d;
  logic [1:0]            state_q, state_d;
  logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
  logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
  logic [DATA_WIDTH-1:0] rx_hold_q, rx_hold_d;
  logic                  word_done_q, word_done_d;
  logic                  reload_pend_q, reload_pend_d;
  logic                  ovf_q, ovf_d;
  logic                  unr_q, unr_d;

  logic sclk_rise, sclk_fall, cs_n_s, mosi_s;
  logic reload, pop, unr_set, push, ovf_set;

  assign sclk_rise = sclk_q[1] & ~sclk_q[2];
  assign sclk_fall = ~sclk_q[1] & sclk_q[2];
  assign cs_n_s    = cs_q[1];
  assign mosi_s    = mosi_q[1];

  always_comb begin
    sclk_d        = {sclk_q[1:0], spi_sclk_i};
    cs_d          = {cs_q[0], spi_cs_ni};
    mosi_d        = {mosi_q[0], spi_mosi_i};
    vld_pipe_d    = {vld_pipe_q[0], 1'b1};
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    tx_shift_d    = tx_shift_q;
    rx_shift_d    = rx_shift_q;
    word_done_d   = 1'b0;
    reload_pend_d = reload_pend_q;
    reload        = 1'b0;

    case (state_q)
      ST_WAIT_IDLE: if (vld_pipe_q[1] && cs_n_s) state_d = ST_IDLE;
      ST_IDLE:      if (!cs_n_s) state_d = ST_LOAD;
      ST_LOAD: begin
        reload    = 1'b1;
        bit_cnt_d = '0;
        state_d   = ST_SHIFT;
      end
      default: begin
        // cs_n deassertion wins over any sclk edge seen in the same cycle
        if (cs_n_s) begin
          state_d       = ST_IDLE;
          bit_cnt_d     = '0;
          reload_pend_d = 1'b0;
        end else if (sclk_rise) begin
          rx_shift_d = {rx_shift_q[DATA_WIDTH-2:0], mosi_s};
          if (bit_cnt_q == CW'(DATA_WIDTH - 1)) begin
            bit_cnt_d     = '0;
            word_done_d   = 1'b1;
            reload_pend_d = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else if (sclk_fall) begin
          if (reload_pend_q) reload = 1'b1;
          else               tx_shift_d = tx_shift_q << 1;
        end
      end
    endcase

    pop     = 1'b0;
    unr_set = 1'b0;
    if (reload) begin
      reload_pend_d = 1'b0;
      if (tx_notempty_i) begin
        tx_shift_d = tx_data_i;
        pop        = 1'b1;
      end else begin
        tx_shift_d = DUMMY_WORD;
        unr_set    = 1'b1;
      end
    end

    // The completed word sits in rx_shift_q for the whole push cycle: the
    // clock ratio keeps the next sclk_rise several cycles away.
    push      = word_done_q & rx_notfull_i;
    ovf_set   = word_done_q & ~rx_notfull_i;
    rx_hold_d = push ? rx_shift_q : rx_hold_q;

    ovf_d = ovf_set | (ovf_q & ~err_clr_i);
    unr_d = unr_set | (unr_q & ~err_clr_i);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sclk_q        <= '0;
      cs_q          <= '1;
      mosi_q        <= '0;
      vld_pipe_q    <= '0;
      state_q       <= ST_WAIT_IDLE;
      bit_cnt_q     <= '0;
      tx_shift_q    <= '0;
      rx_shift_q    <= '0;
      rx_hold_q     <= '0;
      word_done_q   <= 1'b0;
      reload_pend_q <= 1'b0;
      ovf_q         <= 1'b0;
      unr_q         <= 1'b0;
    end else begin
      sclk_q        <= sclk_d;
      cs_q          <= cs_d;
      mosi_q        <= mosi_d;
      vld_pipe_q    <= vld_pipe_d;
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      tx_shift_q    <= tx_shift_d;
      rx_shift_q    <= rx_shift_d;
      rx_hold_q     <= rx_hold_d;
      word_done_q   <= word_done_d;
      reload_pend_q <= reload_pend_d;
      ovf_q         <= ovf_d;
      unr_q         <= unr_d;
    end
  end

  assign busy_o        = (state_q == ST_LOAD) || (state_q == ST_SHIFT);
  assign spi_miso_oe_o = busy_o;
  assign spi_miso_o    = busy_o & tx_shift_q[DATA_WIDTH-1];
  assign tx_pop_o      = pop;
  assign rx_push_o     = push;
  assign rx_data_o     = push ? rx_shift_q : rx_hold_q;
  assign rx_overflow_o = ovf_q;
  assign tx_underrun_o = unr_q;

endmodule

// File: tb/tb_spi_slave_engine.sv
// tb_spi_slave_engine -- directed bench for spi_slave_engine (DATA_WIDTH=8).
// A table of whole-frame vectors drives an SPI master model and small FIFO
// models; hand-written sequences cover reset, mid-word abort and reset
// during a transfer.
module tb_spi_slave_engine;

  logic       clk = 1'b0;
  logic       rst, sclk, cs_n, mosi, err_clr, rx_notfull;
  logic       miso, miso_oe, tx_pop, rx_push, busy, ovf, unr;
  logic [7:0] tx_data, rx_data;
  logic       tx_notempty;

  logic [7:0] tx_mem [0:3];
  int         tx_rd = 0, tx_wr = 0;
  logic       pop_pend = 1'b0;
  int         pops = 0, pushes = 0;
  logic [7:0] rx_log [0:31];

  int n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  assign tx_notempty = (tx_rd != tx_wr);
  assign tx_data     = tx_mem[tx_rd & 3];

  spi_slave_engine #(.DATA_WIDTH(8)) dut (
    .clk_i(clk), .rst_i(rst),
    .spi_sclk_i(sclk), .spi_cs_ni(cs_n), .spi_mosi_i(mosi),
    .spi_miso_o(miso), .spi_miso_oe_o(miso_oe),
    .tx_data_i(tx_data), .tx_notempty_i(tx_notempty), .tx_pop_o(tx_pop),
    .rx_data_o(rx_data), .rx_notfull_i(rx_notfull), .rx_push_o(rx_push),
    .busy_o(busy), .rx_overflow_o(ovf), .tx_underrun_o(unr),
    .err_clr_i(err_clr)
  );

  // FIFO-side monitor. The read pointer advances one negedge after the pop
  // strobe is seen, i.e. after the DUT has captured the head word.
  always @(negedge clk) begin
    if (pop_pend) begin
      tx_rd    = tx_rd + 1;
      pop_pend = 1'b0;
    end
    if (tx_pop) begin
      pops     = pops + 1;
      pop_pend = 1'b1;
    end
    if (rx_push) begin
      rx_log[pushes & 31] = rx_data;
      pushes              = pushes + 1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time budget");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_miso"},    {31'd0, miso},    0);
    chk({tag, "_miso_oe"}, {31'd0, miso_oe}, 0);
    chk({tag, "_busy"},    {31'd0, busy},    0);
    chk({tag, "_pop"},     {31'd0, tx_pop},  0);
    chk({tag, "_push"},    {31'd0, rx_push}, 0);
    chk({tag, "_ovf"},     {31'd0, ovf},     0);
    chk({tag, "_unr"},     {31'd0, unr},     0);
    chk({tag, "_rx_data"}, {24'd0, rx_data}, 0);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Mode 0 master: MOSI changes with sclk low, MISO sampled just before
  // the rising edge. Half period is 5 clk cycles.
  task automatic xfer_word(input logic [7:0] w, input int nbits, output logic [7:0] mi);
    mi = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      mosi = w[7-i];
      cyc(5);
      mi[7-i] = miso;
      sclk = 1'b1;
      cyc(5);
      sclk = 1'b0;
    end
  endtask

  task automatic fifo_load(input int n, input logic [7:0] a, input logic [7:0] b);
    tx_wr = tx_rd;
    if (n > 0) tx_mem[tx_rd & 3]       = a;
    if (n > 1) tx_mem[(tx_rd + 1) & 3] = b;
    tx_wr = tx_rd + n;
  endtask

  task automatic clr_flags();
    err_clr = 1'b1;
    cyc(1);
    err_clr = 1'b0;
    cyc(1);
  endtask

  task automatic simple_frame(input logic [7:0] w, input string tag);
    logic [7:0] mi;
    int q0;
    q0   = pushes;
    cs_n = 1'b0;
    cyc(8);
    xfer_word(w, 8, mi);
    cyc(3);
    cs_n = 1'b1;
    cyc(8);
    chk({tag, "_npush"}, pushes - q0, 1);
    chk({tag, "_rx"}, {24'd0, rx_log[q0 & 31]}, {24'd0, w});
  endtask

  typedef struct {
    string      name;
    int         ntx;
    logic [7:0] tx0, tx1;
    int         nw;
    logic [7:0] mo0, mo1;
    logic       nf;
    logic [7:0] mi0, mi1;
    int         npush;
    logic [7:0] rx0, rx1;
    logic       ovf, unr;
  } vec_t;

  vec_t vecs [0:4];

  initial begin
    logic [7:0] mi;
    int p0, q0, exp_p;
    vec_t v;

    // name      ntx tx0    tx1    nw mo0    mo1    nf  mi0    mi1    np rx0    rx1    ovf  unr
    vecs[0] = '{"single", 1, 8'hA5, 8'h00, 1, 8'h3C, 8'h00, 1'b1, 8'hA5, 8'h00, 1, 8'h3C, 8'h00, 1'b0, 1'b1};
    vecs[1] = '{"b2b",    2, 8'h11, 8'h22, 2, 8'hF0, 8'h0F, 1'b1, 8'h11, 8'h22, 2, 8'hF0, 8'h0F, 1'b0, 1'b1};
    vecs[2] = '{"underrun",0,8'h00, 8'h00, 1, 8'h55, 8'h00, 1'b1, 8'hFF, 8'h00, 1, 8'h55, 8'h00, 1'b0, 1'b1};
    vecs[3] = '{"overflow",1,8'h5A, 8'h00, 1, 8'h99, 8'h00, 1'b0, 8'h5A, 8'h00, 0, 8'h00, 8'h00, 1'b1, 1'b1};
    vecs[4] = '{"after_ovf",2,8'h11,8'h22, 1, 8'h66, 8'h00, 1'b1, 8'h11, 8'h00, 1, 8'h66, 8'h00, 1'b0, 1'b0};

    rst = 1'b1; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
    err_clr = 1'b0; rx_notfull = 1'b1;
    cyc(3);
    rst = 1'b0;
    chk_outputs_zero("reset");
    cyc(6);

    for (int k = 0; k < 5; k++) begin
      v = vecs[k];
      fifo_load(v.ntx, v.tx0, v.tx1);
      rx_notfull = v.nf;
      p0 = pops;
      q0 = pushes;
      cs_n = 1'b0;
      cyc(8);
      chk({v.name, "_busy_in"}, {31'd0, busy}, 1);
      for (int w = 0; w < v.nw; w++) begin
        xfer_word(w == 0 ? v.mo0 : v.mo1, 8, mi);
        chk($sformatf("%s_miso%0d", v.name, w), {24'd0, mi}, {24'd0, (w == 0 ? v.mi0 : v.mi1)});
        cyc(5);
        // one pop at frame start plus one on each word's last falling edge
        exp_p = (v.ntx < w + 2) ? v.ntx : w + 2;
        chk($sformatf("%s_pops%0d", v.name, w), pops - p0, exp_p);
      end
      cs_n = 1'b1;
      cyc(8);
      chk({v.name, "_busy_out"}, {31'd0, busy},    0);
      chk({v.name, "_miso_idle"},{31'd0, miso},    0);
      chk({v.name, "_npush"},    pushes - q0,      v.npush);
      for (int j = 0; j < v.npush; j++)
        chk($sformatf("%s_rx%0d", v.name, j), {24'd0, rx_log[(q0 + j) & 31]},
            {24'd0, (j == 0 ? v.rx0 : v.rx1)});
      chk({v.name, "_ovf"}, {31'd0, ovf}, {31'd0, v.ovf});
      chk({v.name, "_unr"}, {31'd0, unr}, {31'd0, v.unr});
      clr_flags();
      chk({v.name, "_ovf_clr"}, {31'd0, ovf}, 0);
      chk({v.name, "_unr_clr"}, {31'd0, unr}, 0);
      rx_notfull = 1'b1;
    end

    // Mid-word abort: five bits, then cs_n rises -> nothing pushed
    fifo_load(0, 8'h00, 8'h00);
    q0   = pushes;
    cs_n = 1'b0;
    cyc(8);
    xfer_word(8'hB7, 5, mi);
    cyc(3);
    cs_n = 1'b1;
    cyc(8);
    chk("abort_npush", pushes - q0, 0);
    chk("abort_busy", {31'd0, busy}, 0);
    simple_frame(8'hC3, "abort_next");

    // Reset after bit 3 with cs_n held low
    q0   = pushes;
    cs_n = 1'b0;
    cyc(8);
    xfer_word(8'hFF, 3, mi);
    chk("rstmid_unr_before", {31'd0, unr}, 1);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    chk_outputs_zero("rstmid");
    xfer_word(8'hFF, 5, mi);
    cyc(8);
    chk("rstmid_busy_after", {31'd0, busy}, 0);
    chk("rstmid_npush", pushes - q0, 0);
    chk("rstmid_oe_after", {31'd0, miso_oe}, 0);
    cs_n = 1'b1;
    cyc(8);
    simple_frame(8'h81, "rstmid_next");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_slave_engine.md
Name: spi_slave_engine

Overview:
- SPI slave (responder) shift engine: the far-end counterpart of the APB-to-SPI master datapath.
- Receives MOSI words into an RX FIFO and drives MISO words taken from a TX FIFO.
- SPI pins are oversampled and synchronised into the clk_i domain.
- FIFO side uses the team's FIFO handshake: push only when not-full, pop only when not-empty.
- SPI mode 0 (CPOL=0, CPHA=0), MSB first, words of DATA_WIDTH bits, multiple words per cs_n frame.

Parameters:
- DATA_WIDTH, 8, SPI word width in bits (>=2).
- DUMMY_WORD, all ones (DATA_WIDTH bits), word shifted out on MISO when the TX FIFO is empty at word start.

Ports:
- clk_i  in  1  system clock; must be >=6x the SPI sclk frequency.
- rst_i  in  1  synchronous reset, active high.
- spi_sclk_i  in  1  SPI clock pin, asynchronous to clk_i.
- spi_cs_ni  in  1  chip select, active low, asynchronous.
- spi_mosi_i  in  1  master-out data, asynchronous.
- spi_miso_o  out  1  slave-out data.
- spi_miso_oe_o  out  1  MISO output enable; 1 while the frame is active.
- tx_data_i  in  DATA_WIDTH  head of the TX FIFO.
- tx_notempty_i  in  1  TX FIFO holds a word.
- tx_pop_o  out  1  one-cycle pop strobe to the TX FIFO.
- rx_data_o  out  DATA_WIDTH  received word; valid while rx_push_o=1.
- rx_notfull_i  in  1  RX FIFO can accept a word.
- rx_push_o  out  1  one-cycle push strobe to the RX FIFO.
- busy_o  out  1  frame in progress (state LOAD or SHIFT).
- rx_overflow_o  out  1  sticky: a completed word was dropped because the RX FIFO was full.
- tx_underrun_o  out  1  sticky: DUMMY_WORD was sent because the TX FIFO was empty.
- err_clr_i  in  1  clears both sticky flags.

Behaviour:
- **Synchronisers.**
  - sclk, cs_n and mosi each pass through 2 flops, plus a third flop on sclk for edge detection.
  - sclk_rise/sclk_fall strobes are valid 3 clk_i cycles after the pin edge.
  - On reset, the sync flops take: sclk=0, cs_n=1, mosi=0.
- **FSM states:** WAIT_IDLE, IDLE, LOAD, SHIFT.
  - Reset state: WAIT_IDLE.
  - WAIT_IDLE: leave to IDLE only once synced cs_n=1. This prevents joining a frame mid-word after reset.
  - IDLE: synced cs_n=0 -> LOAD.
  - LOAD (1 cycle):
    - If tx_notempty_i: tx_shift<=tx_data_i and tx_pop_o=1.
    - Else: tx_shift<=DUMMY_WORD and tx_underrun_o<=1.
    - In both cases bit_cnt<=0, then go to SHIFT.
  - SHIFT, on sclk_rise:
    - rx_shift<={rx_shift[DATA_WIDTH-2:0],mosi_sync}; bit_cnt++.
    - If bit_cnt reaches DATA_WIDTH: word_done and bit_cnt<=0.
  - SHIFT, on sclk_fall:
    - If a word completed since the last load, reload exactly as in LOAD (pop or dummy).
    - Otherwise tx_shift<=tx_shift<<1.
  - SHIFT, synced cs_n=1: go to IDLE immediately. The partial RX word is discarded (no push) and bit_cnt<=0.
- **MISO.**
  - spi_miso_o = tx_shift[DATA_WIDTH-1] while spi_miso_oe_o=1; otherwise spi_miso_o=0.
  - spi_miso_oe_o=1 in LOAD and SHIFT.
- **RX push.**
  - In the cycle after word_done: rx_push_o=1 and rx_data_o=the completed word, if rx_notfull_i.
  - Else: rx_push_o stays 0, the word is lost, and rx_overflow_o<=1.
  - rx_data_o holds its value between pushes.
- **Strobe widths.** tx_pop_o and rx_push_o are each exactly 1 cycle wide, at most one per word.
- **Sticky flags.**
  - Set has priority over err_clr_i in the same cycle.
  - The flags are not cleared by a cs_n deassertion.
- **Width rules.**
  - bit_cnt is $clog2(DATA_WIDTH+1) bits wide and never exceeds DATA_WIDTH.
  - Extra sclk edges after the last word of a frame start a new word.
- **Reset (rst_i=1, any state):** on the next clk_i edge, all outputs go to 0:
  - spi_miso_o, spi_miso_oe_o, tx_pop_o, rx_push_o, busy_o, both flags, and rx_data_o=0.
  - State<=WAIT_IDLE, shift registers 0, bit_cnt 0.
- **Simultaneous events:**
  - cs_n rising together with the last sclk_rise: cs_n wins, and the word is discarded.
  - sclk_rise and sclk_fall in the same cycle cannot happen given the clock-ratio rule.

Test Plan:
- Single word, DATA_WIDTH=8:
  - Stimulus: TX FIFO holds 0xA5; master sends 0x3C in one frame.
  - Required: MISO bit stream 1,0,1,0,0,1,0,1; exactly one tx_pop_o; one rx_push_o with rx_data_o=0x3C; busy_o drops after cs_n rises.
- Back-to-back words:
  - Stimulus: TX FIFO holds 0x11, 0x22; master sends 0xF0, 0x0F in one frame.
  - Required: two pops, the second on the 8th falling edge; pushes of 0xF0 then 0x0F; MISO carries 0x11 then 0x22.
- TX underrun:
  - Stimulus: TX FIFO empty; master sends 0x55.
  - Required: MISO reads 0xFF; tx_underrun_o=1 and stays 1; rx_push_o delivers 0x55.
  - Then pulse err_clr_i -> tx_underrun_o returns to 0.
- RX overflow:
  - Stimulus: rx_notfull_i=0; master sends 0x99.
  - Required: no rx_push_o; rx_overflow_o=1.
  - Then with rx_notfull_i=1 the next word 0x66 is pushed normally.
- Mid-word abort:
  - Stimulus: cs_n rises after 5 sclk cycles.
  - Required: no push; state IDLE; next frame sending 0xC3 receives exactly 0xC3.
- Reset mid-transfer:
  - Stimulus: rst_i for 1 cycle after bit 3 while cs_n stays low.
  - Required: all outputs 0; the engine ignores the rest of the frame.
  - After cs_n goes high then low, the next word 0x81 is received correctly.
